div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand width in bits; only 32 is required to be supported.
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Port signed_div_i  input  1  SHALL select the operation: 1 = signed divide, 0 = unsigned divide.
REQ-005 Port opdata1_i  input  32  SHALL carry the dividend.
REQ-006 Port opdata2_i  input  32  SHALL carry the divisor.
REQ-007 Port start_i  input  1  SHALL be the division request from EX, held high until ready_o is seen.
REQ-008 Port annul_i  input  1  SHALL cancel the division in progress.
REQ-009 Port result_o  output  64  SHALL carry the result: [63:32] = remainder (HI), [31:0] = quotient (LO).
REQ-010 Port ready_o  output  1  SHALL indicate that result_o is valid.
REQ-011 Port busy_o  output  1  SHALL be high while the state is DIV_ON or DIV_BY_ZERO; it is decoded combinationally from the state.

Function
REQ-012 The controller SHALL be an FSM with four states: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
REQ-013 In DIV_FREE, with start_i=1, annul_i=0 and opdata2_i!=0, the block SHALL latch the operands and signed_div_i, clear the iteration counter and enter DIV_ON.
REQ-014 In DIV_FREE, with start_i=1, annul_i=0 and opdata2_i==0, the block SHALL enter DIV_BY_ZERO.
REQ-015 In DIV_FREE, start_i=1 together with annul_i=1 SHALL be ignored, and the state SHALL remain DIV_FREE.
REQ-016 For a signed operation, the operands SHALL be converted to magnitudes (two's-complement negation of negative values) when latched.
REQ-017 DIV_ON SHALL perform one restoring shift-subtract step per clock, producing 1 quotient bit per step.
REQ-018 After exactly 32 steps, DIV_ON SHALL transition to DIV_END.
REQ-019 On entry to DIV_END, ready_o SHALL be registered to 1 and result_o SHALL be registered; ready_o is first high 33 edges after the edge that sampled start_i.
REQ-020 Signed result correction: the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-021 The case 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0, by natural wrap.
REQ-022 DIV_BY_ZERO SHALL transition to DIV_END on the next edge, with result_o=0 and ready_o=1.
REQ-023 In DIV_END, while start_i=1, the state SHALL hold and ready_o and result_o SHALL be stable.
REQ-024 In DIV_END, when start_i=0, the block SHALL enter DIV_FREE next edge with ready_o=0 and result_o=0.
REQ-025 annul_i=1 in DIV_ON, DIV_BY_ZERO or DIV_END SHALL force DIV_FREE next edge with ready_o=0 and result_o=0; annul takes priority over all other transitions.
REQ-026 Operand input changes after latching SHALL NOT affect an operation in progress.

Reset
REQ-027 When rst=0, the block SHALL immediately, without waiting for clk, force state=DIV_FREE, counter=0, ready_o=0, result_o=0 and all operand/partial-remainder registers to 0.
REQ-028 Reset asserted mid-operation SHALL abandon the division, and no ready_o SHALL follow after rst is released.

Structure
REQ-029 The following SHALL reside in the shared defines package: state encodings DIV_FREE/DIV_BY_ZERO/DIV_ON/DIV_END, result-ready/not-ready constants, and the ALU opcode constants for DIV and DIVU.
REQ-030 The block SHALL contain one combinational sub-module div_step (33-bit trial subtract, shift, and quotient-bit insert); the FSM, counter and sign correction SHALL live in div_ctrl.

Verification
REQ-031 The bench SHALL cover: unsigned 100/7, start held -> ready_o high 33 edges after start; result_o={32'd2,32'd14}; held stable while start_i=1.
REQ-032 The bench SHALL cover: signed -7/2 -> result_o={0xFFFFFFFF,0xFFFFFFFD}; start_i dropped -> ready_o=0 and result_o=0 next edge.
REQ-033 The bench SHALL cover: 5/0 -> busy_o high for 1 cycle; ready_o high after 2nd edge; result_o=0.
REQ-034 The bench SHALL cover: annul_i pulsed at step 10 -> DIV_FREE next edge and ready_o never rises; then unsigned 0xFFFFFFFF/1 -> result_o={0,0xFFFFFFFF}.
REQ-035 The bench SHALL cover: rst=0 asserted between clock edges at step 20 -> outputs 0 before the next edge; after release, idle with no spurious ready_o.
REQ-036 The bench SHALL cover: signed 0x80000000/0xFFFFFFFF -> result_o={0,0x80000000}.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared defines for the multi-cycle divider: FSM state encodings,
// result-ready flags and the ALU opcodes that route work to the divider.
package div_ctrl_pkg;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One restoring divide step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift in the quotient bit.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    assign shifted = {rem, quo[DATA_W-1]};
    // Since rem < divisor, the top bit of the trial difference is a clean borrow flag.
    assign diff     = shifted - {1'b0, divisor};
    assign rem_next = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], ~diff[DATA_W]};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller: latches operand magnitudes,
// runs DATA_W restoring steps, then applies sign correction to HI/LO.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic              neg_quo;
    logic              neg_rem;

    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] op1_mag;
    logic [DATA_W-1:0] op2_mag;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic              op1_neg;
    logic              op2_neg;

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign op1_neg = signed_div_i && opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i && opdata2_i[DATA_W-1];
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    // Negating 0x8000_0000 wraps back to itself, which is the required signed-overflow answer.
    assign quo_fix = neg_quo ? -quo : quo;
    assign rem_fix = neg_rem ? -rem : rem;

    assign busy_o = (state == DIV_ON) || (state == DIV_BY_ZERO);

    // NOTE: every register here uses <= so all next-state values are computed
    // from the same pre-edge snapshot, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                        end else begin
                            state   <= DIV_ON;
                            cnt     <= '0;
                            rem     <= '0;
                            quo     <= op1_mag;
                            divisor <= op2_mag;
                            neg_quo <= op1_neg ^ op2_neg;
                            neg_rem <= op1_neg;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        state    <= DIV_END;
                        ready_o  <= DIV_RESULT_READY;
                        result_o <= '0;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state    <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else if (cnt == LAST_STEP) begin
                        state    <= DIV_END;
                        ready_o  <= DIV_RESULT_READY;
                        result_o <= {rem_fix, quo_fix};
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    if (annul_i || !start_i) begin
                        state    <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
